// File: rtl/rsa_serial_link_tx_if.sv
// Frame-offer bus for rsa_serial_link_tx: valid/ready handshake carrying n, d, N and ciphertext.
interface rsa_serial_link_tx_if #(
    parameter int unsigned A = 5
);
    localparam int unsigned DATA_W = 1 << A;

    logic              in_valid;
    logic              in_ready;
    logic [3:0]        n_in;
    logic [DATA_W-1:0] d_in;
    logic [DATA_W-1:0] N_in;
    logic [DATA_W-1:0] ct_in;

    modport master (output in_valid, n_in, d_in, N_in, ct_in, input in_ready);
    modport slave  (input in_valid, n_in, d_in, N_in, ct_in, output in_ready);
endinterface

// File: rtl/rsa_serial_link_tx.sv
// rsa_serial_link_tx: serialises one (n, d, N, ct) frame onto the two-wire (mode, str) link:
// key load with mode=1, pulse-width-coded ciphertext bits, a one-cycle terminator and an idle gap.
// Optional macro RSA_TX_FRAME_CNT_EN adds frame_cnt (wrapping) and rej_cnt (saturating) outputs.
module rsa_serial_link_tx #(
    parameter int unsigned A         = 5,
    parameter int unsigned ONE_HIGH  = 8,
    parameter int unsigned ONE_LOW   = 4,
    parameter int unsigned ZERO_HIGH = 4,
    parameter int unsigned ZERO_LOW  = 8,
    parameter int unsigned GAP       = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    rsa_serial_link_tx_if.slave     bus,
    output logic                    mode,
    output logic                    str,
    output logic                    done,
    output logic                    err
`ifdef RSA_TX_FRAME_CNT_EN
    ,
    output logic [15:0]             frame_cnt,
    output logic [7:0]              rej_cnt
`endif
);
    localparam int unsigned DATA_W  = 1 << A;
    localparam int unsigned N_W     = 4;
    localparam int unsigned KEY_LEN = N_W + 2 * DATA_W;
    localparam int unsigned CNT_W   = A + 2;
    localparam int unsigned PH_W    = 6;

    localparam bit CFG_OK = (ONE_HIGH > ONE_LOW) && (ZERO_HIGH <= ZERO_LOW)
        && (ONE_HIGH >= 1) && (ONE_LOW >= 1) && (ZERO_HIGH >= 1) && (ZERO_LOW >= 1)
        && (ONE_HIGH + ONE_LOW >= 10) && (ONE_HIGH + ONE_LOW <= 60)
        && (ZERO_HIGH + ZERO_LOW >= 10) && (ZERO_HIGH + ZERO_LOW <= 60)
        && (GAP >= 3) && (GAP <= 64) && (A >= 1);

    // Reject illegal pulse timing at elaboration.
    generate
        if (!CFG_OK) begin : g_bad_cfg
            $fatal(1, "rsa_serial_link_tx: illegal timing parameters");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE, S_KEY, S_BIT_HI, S_BIT_LO, S_TERM, S_GAP
    } state_t;

    state_t              state, state_d;
    logic [CNT_W-1:0]    cnt, cnt_d;
    logic [PH_W-1:0]     ph, ph_d;
    logic [N_W-1:0]      n_q;
    logic [DATA_W-1:0]   d_q, modn_q, ct_q;
    logic                mode_d, str_d, done_d, err_d, load_c;
    logic [KEY_LEN-1:0]  key_vec_c;
    logic [CNT_W-1:0]    key_idx_c;
    logic                bit_c, hi_last_c, lo_last_c;

    assign bus.in_ready = (state == S_IDLE);

    // Key stream and current-bit pulse lengths.
    assign key_vec_c = {n_q, d_q, modn_q};
    assign key_idx_c = CNT_W'(KEY_LEN - 1) - cnt;
    assign bit_c     = ct_q[cnt[A-1:0]];
    assign hi_last_c = (ph == (bit_c ? PH_W'(ONE_HIGH - 1) : PH_W'(ZERO_HIGH - 1)));
    assign lo_last_c = (ph == (bit_c ? PH_W'(ONE_LOW - 1)  : PH_W'(ZERO_LOW - 1)));

    // Next-state and next-output logic; outputs land one cycle after the state that produces them.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        ph_d    = ph;
        mode_d  = 1'b0;
        str_d   = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        load_c  = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    if (bus.n_in > N_W'(A)) begin
                        err_d = 1'b1;
                    end else begin
                        load_c  = 1'b1;
                        cnt_d   = '0;
                        state_d = S_KEY;
                    end
                end
            end
            S_KEY: begin
                mode_d = 1'b1;
                str_d  = key_vec_c[key_idx_c];
                if (cnt == CNT_W'(KEY_LEN - 1)) begin
                    cnt_d   = (CNT_W'(1) << n_q) - CNT_W'(1);
                    ph_d    = '0;
                    state_d = S_BIT_HI;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            S_BIT_HI: begin
                str_d = 1'b1;
                if (hi_last_c) begin
                    ph_d    = '0;
                    state_d = S_BIT_LO;
                end else begin
                    ph_d = ph + PH_W'(1);
                end
            end
            S_BIT_LO: begin
                if (lo_last_c) begin
                    ph_d = '0;
                    if (cnt == '0) begin
                        state_d = S_TERM;
                    end else begin
                        cnt_d   = cnt - CNT_W'(1);
                        state_d = S_BIT_HI;
                    end
                end else begin
                    ph_d = ph + PH_W'(1);
                end
            end
            S_TERM: begin
                str_d   = 1'b1;
                ph_d    = '0;
                state_d = S_GAP;
            end
            S_GAP: begin
                if (ph == PH_W'(GAP - 1)) begin
                    done_d  = 1'b1;
                    ph_d    = '0;
                    state_d = S_IDLE;
                end else begin
                    ph_d = ph + PH_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, counters, frame registers and registered link outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            ph     <= '0;
            n_q    <= '0;
            d_q    <= '0;
            modn_q <= '0;
            ct_q   <= '0;
            mode   <= 1'b0;
            str    <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            ph    <= ph_d;
            mode  <= mode_d;
            str   <= str_d;
            done  <= done_d;
            err   <= err_d;
            if (load_c) begin
                n_q    <= bus.n_in;
                d_q    <= bus.d_in;
                modn_q <= bus.N_in;
                ct_q   <= bus.ct_in;
            end
        end
    end

`ifdef RSA_TX_FRAME_CNT_EN
    // Completed-frame counter (wraps) and rejected-frame counter (saturates).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_cnt <= '0;
            rej_cnt   <= '0;
        end else begin
            if (done_d) frame_cnt <= frame_cnt + 16'd1;
            if (err_d && (rej_cnt != 8'hFF)) rej_cnt <= rej_cnt + 8'd1;
        end
    end
`endif
endmodule

// File: tb/tb_rsa_serial_link_tx.sv
// Testbench for rsa_serial_link_tx: random frames checked against a cycle-level waveform model
// and a receiver-style pulse-width decoder.
module tb_rsa_serial_link_tx;
    localparam int unsigned A  = 5;
    localparam int unsigned OH = 8;
    localparam int unsigned OL = 4;
    localparam int unsigned ZH = 4;
    localparam int unsigned ZL = 8;
    localparam int unsigned GP = 4;

    logic clk;
    logic reset;
    logic mode, str, done, err;
`ifdef RSA_TX_FRAME_CNT_EN
    logic [15:0] frame_cnt;
    logic [7:0]  rej_cnt;
`endif

    int n_cmp;
    int n_bad;
    int frames_done;
    int frames_rej;

    logic [1:0] cap[$];
    logic [1:0] exp_q[$];
    int         done_at;
    bit         ready_ok;
    bit         err_seen;

    rsa_serial_link_tx_if #(.A(A)) bus();

    rsa_serial_link_tx #(
        .A(A), .ONE_HIGH(OH), .ONE_LOW(OL), .ZERO_HIGH(ZH), .ZERO_LOW(ZL), .GAP(GP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .mode(mode),
        .str(str),
        .done(done),
        .err(err)
`ifdef RSA_TX_FRAME_CNT_EN
        ,
        .frame_cnt(frame_cnt),
        .rej_cnt(rej_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {mode,str} per cycle after the accept edge, built directly from the link rules.
    task automatic build_model(input logic [3:0] n, input logic [31:0] d, m, ct);
        exp_q.delete();
        for (int i = 3; i >= 0; i--) exp_q.push_back({1'b1, n[i]});
        for (int i = 31; i >= 0; i--) exp_q.push_back({1'b1, d[i]});
        for (int i = 31; i >= 0; i--) exp_q.push_back({1'b1, m[i]});
        for (int b = (1 << n) - 1; b >= 0; b--) begin
            int unsigned h, l;
            h = ct[b] ? OH : ZH;
            l = ct[b] ? OL : ZL;
            repeat (h) exp_q.push_back(2'b01);
            repeat (l) exp_q.push_back(2'b00);
        end
        exp_q.push_back(2'b01);
        repeat (GP) exp_q.push_back(2'b00);
    endtask

    function automatic int first_diff();
        if (cap.size() != exp_q.size())
            return (cap.size() < exp_q.size()) ? cap.size() : exp_q.size();
        for (int i = 0; i < cap.size(); i++)
            if (cap[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    // Receiver view: key bits while mode=1, then high/low run lengths decoded to bits.
    task automatic decode(output logic [3:0] n_o, output logic [31:0] d_o, m_o, ct_o,
                          output int nbits);
        logic [67:0] key;
        int          runs[$];
        int          r;
        logic        lvl;
        key = '0; n_o = '0; d_o = '0; m_o = '0; ct_o = '0; nbits = -1;
        if (cap.size() < 72) return;
        for (int i = 0; i < 68; i++) begin
            if (cap[i][1] !== 1'b1) return;
            key = {key[66:0], cap[i][0]};
        end
        {n_o, d_o, m_o} = key;
        if (cap[68] !== 2'b01) return;
        lvl = 1'b1;
        r = 0;
        for (int i = 68; i < cap.size(); i++) begin
            if (cap[i][1] !== 1'b0) return;
            if (cap[i][0] === lvl) r++;
            else begin
                runs.push_back(r);
                r = 1;
                lvl = cap[i][0];
            end
        end
        runs.push_back(r);
        if ((runs.size() % 2) != 0 || runs.size() < 4) return;
        if (runs[runs.size() - 2] != 1) return;
        nbits = runs.size() / 2 - 1;
        for (int b = 0; b < nbits; b++) ct_o = {ct_o[30:0], runs[2*b] > runs[2*b+1]};
    endtask

    // Waits for in_ready, drives a frame, and returns just after the accept edge (valid still high).
    task automatic offer(input logic [3:0] n, input logic [31:0] d, m, ct, output bit ok);
        int w;
        w = 0;
        ok = 1'b0;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && w < 3000) begin
            @(negedge clk);
            w++;
        end
        if (bus.in_ready === 1'b1) begin
            bus.n_in = n; bus.d_in = d; bus.N_in = m; bus.ct_in = ct;
            bus.in_valid = 1'b1;
            @(negedge clk);
            ok = 1'b1;
        end
    endtask

    // Records {mode,str} each cycle after the accept edge until done (bounded).
    task automatic capture();
        cap.delete();
        done_at = -1;
        ready_ok = 1'b1;
        err_seen = 1'b0;
        for (int j = 1; j <= 3000; j++) begin
            @(negedge clk);
            cap.push_back({mode, str});
            if (err === 1'b1) err_seen = 1'b1;
            if (done === 1'b1) begin
                done_at = j;
                if (bus.in_ready !== 1'b1) ready_ok = 1'b0;
                frames_done++;
                break;
            end else if (bus.in_ready !== 1'b0) begin
                ready_ok = 1'b0;
            end
        end
    endtask

    task automatic do_frame(input logic [3:0] n, input logic [31:0] d, m, ct, output bit ok);
        offer(n, d, m, ct, ok);
        bus.in_valid = 1'b0;
        if (ok) capture();
        build_model(n, d, m, ct);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({mode, str, done, err} !== 4'b0000) begin
            n_bad++; $display("FAIL reset_outputs: got %b expected 0000", {mode, str, done, err});
        end
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_ready: got %b expected 1", bus.in_ready);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({mode, str, done, err, bus.in_ready} !== 5'b00001) begin
            n_bad++; $display("FAIL idle_after_reset: got %b expected 00001",
                              {mode, str, done, err, bus.in_ready});
        end
`ifdef RSA_TX_FRAME_CNT_EN
        n_cmp++;
        if (frame_cnt !== 16'd0 || rej_cnt !== 8'd0) begin
            n_bad++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", frame_cnt, rej_cnt);
        end
`endif
    endtask

    task automatic test_single();
        bit ok;
        logic [31:0] ct;
        ct = ($urandom() & 32'hFFFF_FFF0) | 32'h0000_000A;
        do_frame(4'd2, $urandom(), $urandom(), ct, ok);
        n_cmp++;
        if (!ok || done_at != 121) begin
            n_bad++; $display("FAIL single_done_latency: got %0d expected 121", done_at);
        end
        n_cmp++;
        if (first_diff() != -1) begin
            n_bad++; $display("FAIL single_waveform: first diff at cycle %0d", first_diff() + 1);
        end
        n_cmp++;
        if (!ready_ok || err_seen) begin
            n_bad++; $display("FAIL single_ready_err: got ready_ok=%0d err=%0d expected 1/0",
                              ready_ok, err_seen);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0) begin
            n_bad++; $display("FAIL single_done_width: got %b expected 0", done);
        end
    endtask

    task automatic test_full();
        bit ok;
        logic [3:0]  n_o;
        logic [31:0] d_o, m_o, ct_o;
        int          nb;
        do_frame(4'd5, 32'h0000_0007, 32'h0000_00BB, 32'hDEADBEEF, ok);
        decode(n_o, d_o, m_o, ct_o, nb);
        n_cmp++;
        if (!ok || nb != 32 || ct_o !== 32'hDEADBEEF) begin
            n_bad++; $display("FAIL full_ct: got %h (%0d bits) expected deadbeef (32 bits)", ct_o, nb);
        end
        n_cmp++;
        if ({n_o, d_o, m_o} !== {4'd5, 32'h7, 32'hBB}) begin
            n_bad++; $display("FAIL full_key: got n=%0d d=%h N=%h expected 5/7/bb", n_o, d_o, m_o);
        end
        n_cmp++;
        if (done_at != exp_q.size()) begin
            n_bad++; $display("FAIL full_done: got %0d expected %0d", done_at, exp_q.size());
        end
    endtask

    task automatic test_reject();
        int bad;
        @(negedge clk);
        bus.n_in = 4'd6; bus.d_in = $urandom(); bus.N_in = $urandom(); bus.ct_in = $urandom();
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        frames_rej++;
        n_cmp++;
        if ({err, bus.in_ready, mode, str, done} !== 5'b11000) begin
            n_bad++; $display("FAIL reject_pulse: got %b expected 11000",
                              {err, bus.in_ready, mode, str, done});
        end
        bad = 0;
        repeat (80) begin
            @(negedge clk);
            if ({err, mode, str, done} !== 4'b0000 || bus.in_ready !== 1'b1) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++; $display("FAIL reject_quiet: got %0d bad cycles expected 0", bad);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [31:0] d1, m1, c1, d2, m2, c2;
        d1 = $urandom(); m1 = $urandom(); c1 = $urandom();
        d2 = $urandom(); m2 = $urandom(); c2 = $urandom();
        offer(4'd1, d1, m1, c1, ok);
        bus.n_in = 4'd0; bus.d_in = d2; bus.N_in = m2; bus.ct_in = c2;
        if (ok) capture();
        build_model(4'd1, d1, m1, c1);
        n_cmp++;
        if (!ok || first_diff() != -1 || done_at != exp_q.size()) begin
            n_bad++; $display("FAIL b2b_first: diff=%0d done_at=%0d expected -1/%0d",
                              first_diff(), done_at, exp_q.size());
        end
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_bad++; $display("FAIL b2b_ready_after_done: got %b expected 1", bus.in_ready);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        n_cmp++;
        if (bus.in_ready !== 1'b0) begin
            n_bad++; $display("FAIL b2b_second_accept: got ready %b expected 0", bus.in_ready);
        end
        capture();
        build_model(4'd0, d2, m2, c2);
        n_cmp++;
        if (first_diff() != -1 || done_at != exp_q.size() || !ready_ok) begin
            n_bad++; $display("FAIL b2b_second: diff=%0d done_at=%0d expected -1/%0d",
                              first_diff(), done_at, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int bad;
        offer(4'($urandom_range(0, 5)), $urandom(), $urandom(), $urandom(), ok);
        bus.in_valid = 1'b0;
        repeat (29) @(negedge clk);
        n_cmp++;
        if (!ok || mode !== 1'b1) begin
            n_bad++; $display("FAIL midreset_in_key: got mode %b expected 1", mode);
        end
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if ({mode, str, bus.in_ready} !== 3'b001) begin
            n_bad++; $display("FAIL midreset_async: got %b expected 001", {mode, str, bus.in_ready});
        end
        @(negedge clk);
        reset = 1'b1;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if ({mode, str, done, err} !== 4'b0000 || bus.in_ready !== 1'b1) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++; $display("FAIL midreset_quiet: got %0d bad cycles expected 0", bad);
        end
`ifdef RSA_TX_FRAME_CNT_EN
        frames_done = 0;
        frames_rej = 0;
`endif
        do_frame(4'd3, $urandom(), $urandom(), $urandom(), ok);
        n_cmp++;
        if (!ok || first_diff() != -1 || done_at != exp_q.size()) begin
            n_bad++; $display("FAIL midreset_next_frame: diff=%0d done_at=%0d expected -1/%0d",
                              first_diff(), done_at, exp_q.size());
        end
    endtask

    task automatic test_n0();
        bit ok;
        do_frame(4'd0, $urandom(), $urandom(), 32'hFFFF_FFFE, ok);
        n_cmp++;
        if (!ok || done_at != 85) begin
            n_bad++; $display("FAIL n0_done_latency: got %0d expected 85", done_at);
        end
        n_cmp++;
        if (first_diff() != -1) begin
            n_bad++; $display("FAIL n0_waveform: first diff at cycle %0d", first_diff() + 1);
        end
    endtask

    task automatic test_random();
        bit ok;
        logic [3:0]  n, n_o;
        logic [31:0] d, m, ct, d_o, m_o, ct_o;
        logic [63:0] mask;
        int          nb;
        for (int t = 0; t < 5; t++) begin
            n = 4'($urandom_range(0, 5));
            d = $urandom(); m = $urandom(); ct = $urandom();
            do_frame(n, d, m, ct, ok);
            mask = (64'd1 << (1 << n)) - 64'd1;
            n_cmp++;
            if (!ok || first_diff() != -1 || done_at != exp_q.size() || !ready_ok || err_seen) begin
                n_bad++; $display("FAIL random_frame%0d: n=%0d diff=%0d done_at=%0d expected -1/%0d",
                                  t, n, first_diff(), done_at, exp_q.size());
            end
            decode(n_o, d_o, m_o, ct_o, nb);
            n_cmp++;
            if (nb != (1 << n) || ct_o !== 32'(64'(ct) & mask) || {n_o, d_o, m_o} !== {n, d, m}) begin
                n_bad++; $display("FAIL random_decode%0d: got ct=%h bits=%0d expected ct=%h bits=%0d",
                                  t, ct_o, nb, 32'(64'(ct) & mask), 1 << n);
            end
        end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; frames_done = 0; frames_rej = 0;
        reset = 1'b0;
        bus.in_valid = 1'b0;
        bus.n_in = '0; bus.d_in = '0; bus.N_in = '0; bus.ct_in = '0;
        test_reset();
        test_single();
        test_full();
        test_reject();
        test_back_to_back();
        test_n0();
        test_reset_mid();
        test_random();
        test_reject();
`ifdef RSA_TX_FRAME_CNT_EN
        @(negedge clk);
        n_cmp++;
        if (frame_cnt !== 16'(frames_done) || rej_cnt !== 8'(frames_rej)) begin
            n_bad++; $display("FAIL counters: got %0d/%0d expected %0d/%0d",
                              frame_cnt, rej_cnt, frames_done, frames_rej);
        end
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
